line_feeder: RTL

Converts one 64-bit host-to-card pixel stream into the three vertically adjacent row streams that the 3×3 filter core consumes on its line1/line2/line3 inputs. It sits between the PCIe stream-1 receive port and the filter, so the host sends each image row once instead of three times. Two internal row buffers hold the previous two rows. Each word of every row from the third row onward is emitted together with the matching words of the two rows above it.

---
 rtl/line_feeder_if.sv | 36 +++
 rtl/line_feeder.sv | 116 +++++++++++
 2 files changed

// File: rtl/line_feeder_if.sv
// Stream-side bundle of line_feeder: one 64-bit input stream and three row output streams.
// The slave modport is the feeder's view; master is the view of whoever surrounds it.
interface line_feeder_if;
  logic [15:0] i_num_lines;
  logic        i_data_valid;
  logic [63:0] i_data;
  logic        o_data_ack;
  logic        o_line1_data_valid;
  logic        o_line2_data_valid;
  logic        o_line3_data_valid;
  logic [63:0] o_line1_data;
  logic [63:0] o_line2_data;
  logic [63:0] o_line3_data;
  logic        i_line1_data_ack;
  logic        i_line2_data_ack;
  logic        i_line3_data_ack;
  logic        o_frame_done;

  modport slave (
    input  i_num_lines, i_data_valid, i_data,
    input  i_line1_data_ack, i_line2_data_ack, i_line3_data_ack,
    output o_data_ack,
    output o_line1_data_valid, o_line2_data_valid, o_line3_data_valid,
    output o_line1_data, o_line2_data, o_line3_data,
    output o_frame_done
  );

  modport master (
    output i_num_lines, i_data_valid, i_data,
    output i_line1_data_ack, i_line2_data_ack, i_line3_data_ack,
    input  o_data_ack,
    input  o_line1_data_valid, o_line2_data_valid, o_line3_data_valid,
    input  o_line1_data, o_line2_data, o_line3_data,
    input  o_frame_done
  );
endinterface

// File: rtl/line_feeder.sv
// Turns one row-major pixel stream into three vertically aligned row streams; outputs valid 1 cycle
// after an input transfer, input ack drops while any pending line output is stalled by its consumer.
module line_feeder #(
  parameter int LINE_WORDS = 64,
  parameter int ADDR_W     = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  line_feeder_if.slave bus
);

  typedef enum logic {FILL, STREAM} state_t;

  state_t            state;
  logic [63:0]       top_mem [LINE_WORDS];
  logic [63:0]       mid_mem [LINE_WORDS];
  logic [ADDR_W-1:0] col;
  logic [15:0]       row;
  logic [15:0]       frame_lines;
  logic              p1, p2, p3;
  logic              last_pending;
  logic [63:0]       line1, line2, line3;
  logic              frame_done;

  logic stall, xfer, load, col_last, end_word;
  logic p1_next, p2_next, p3_next;

  // A pending line only blocks input when its consumer is not taking it this cycle.
  assign stall    = (p1 && !bus.i_line1_data_ack) ||
                    (p2 && !bus.i_line2_data_ack) ||
                    (p3 && !bus.i_line3_data_ack);
  assign bus.o_data_ack = !i_rst && ((state == FILL) || !stall);

  assign xfer     = bus.i_data_valid && bus.o_data_ack;
  assign load     = xfer && (state == STREAM);
  assign col_last = (col == ADDR_W'(LINE_WORDS - 1));
  assign end_word = (state == STREAM) && col_last && (row == frame_lines - 16'd1);

  assign p1_next  = p1 && !bus.i_line1_data_ack;
  assign p2_next  = p2 && !bus.i_line2_data_ack;
  assign p3_next  = p3 && !bus.i_line3_data_ack;

  assign bus.o_line1_data_valid = p1;
  assign bus.o_line2_data_valid = p2;
  assign bus.o_line3_data_valid = p3;
  assign bus.o_line1_data       = line1;
  assign bus.o_line2_data       = line2;
  assign bus.o_line3_data       = line3;
  assign bus.o_frame_done       = frame_done;

  // Row buffers are never cleared; every frame refills them before anything is emitted.
  always_ff @(posedge i_clk) begin
    if (xfer) begin
      top_mem[col] <= mid_mem[col];
      mid_mem[col] <= bus.i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= FILL;
      col          <= '0;
      row          <= '0;
      frame_lines  <= 16'd3;
      p1           <= 1'b0;
      p2           <= 1'b0;
      p3           <= 1'b0;
      last_pending <= 1'b0;
      line1        <= '0;
      line2        <= '0;
      line3        <= '0;
      frame_done   <= 1'b0;
    end else begin
      if (load) begin
        line1        <= top_mem[col];
        line2        <= mid_mem[col];
        line3        <= bus.i_data;
        p1           <= 1'b1;
        p2           <= 1'b1;
        p3           <= 1'b1;
        last_pending <= end_word;
        frame_done   <= 1'b0;
      end else begin
        p1 <= p1_next;
        p2 <= p2_next;
        p3 <= p3_next;
        if (last_pending && !(p1_next || p2_next || p3_next)) begin
          frame_done   <= 1'b1;
          last_pending <= 1'b0;
        end else begin
          frame_done   <= 1'b0;
        end
      end

      if (xfer) begin
        if (row == 16'd0 && col == '0)
          frame_lines <= (bus.i_num_lines < 16'd3) ? 16'd3 : bus.i_num_lines;
        if (col_last) begin
          col <= '0;
          if (end_word) begin
            row   <= '0;
            state <= FILL;
          end else begin
            row <= row + 16'd1;
            // Completing row 1 means both buffers hold real rows from the next transfer on.
            if (row == 16'd1)
              state <= STREAM;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
